alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, clocked successor to the team's 16-bit combinational ALU. It executes add, sub, and, or and xor in one cycle, and runs multiply and divide/modulo iteratively over WIDTH cycles, so wide operands need no large combinational multiplier or divider. It sits between the register-file read stage and writeback and uses a start/busy/done handshake. It keeps the existing opcode encoding and the result/overflow output pairing.

## Interface
- WIDTH, 16: operand and result width; must be at least 4.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request strobe; accepted only while busy=0.
- A  in  WIDTH: operand A, sampled on the accepting edge.
- B  in  WIDTH: operand B, sampled on the accepting edge.
- CTRL  in  3: opcode, sampled on the accepting edge.
- busy  out  1: operation in progress; start is ignored while this is high.
- done  out  1: one-cycle pulse when result, overflow and flags become valid.
- result  out  WIDTH: primary result.
- overflow  out  WIDTH: secondary result (high product half, remainder, or carry/borrow).
- zero  out  1: result == 0, valid with done.
- div_by_zero  out  1: divide attempted with B == 0, valid with done.

## Operation
- Opcodes:
  - 000 add: result = A+B; overflow = {0.., carry-out}.
  - 001 sub: result = A-B; overflow = {0.., borrow} (borrow = A<B unsigned).
  - 010 mul (unsigned): {overflow, result} = A*B, 2·WIDTH-bit product.
  - 011 divmod (unsigned): result = A/B; overflow = A%B.
  - 100 and, 101 or, 110 xor: result = A op B; overflow = 0.
  - 111: result = 0; overflow = 0.
- States:
  - IDLE: start=1 goes to EXEC.
    - Single-cycle ops: result is computed on the same edge; done pulses in the following cycle.
    - 010 goes to MUL.
    - 011 with B≠0 goes to DIV.
    - 011 with B=0 completes as a single-cycle op.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. Counter runs WIDTH-1 down to 0, then goes to IDLE with done.
  - DIV: restoring division, one quotient bit per cycle, MSB first. Same counter and exit as MUL.
- Divide by zero:
  - result = all ones; overflow = A; div_by_zero = 1; no iteration.
- Output hold:
  - result, overflow, zero and div_by_zero hold their last values until the next operation's done.
  - Intermediate iteration values are kept in internal registers and never appear on the outputs.
- start with busy=1 is ignored: no queuing, no error.
- start in the same cycle as done is accepted, because busy is already 0 in that cycle.

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0, zero=0, div_by_zero=0; state=IDLE; counter=0.
- Reset asserted mid-operation aborts it immediately. No done is produced for the aborted op.
- Latency, counted from the accepting edge (cycle 0) to the cycle in which done=1:
  - Single-cycle ops and divide-by-zero: 1.
  - mul and divmod: WIDTH+1.
- busy:
  - Single-cycle ops: stays 0.
  - mul and divmod: 1 from cycle 1 through cycle WIDTH; 0 in the done cycle.
- Back-to-back throughput:
  - Single-cycle ops: one per cycle.
  - mul and divmod: one per WIDTH+1 cycles.
- Operands are registered on the accepting edge; changes to A, B and CTRL afterwards have no effect.

## Structure
- Package alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_XOR, OP_NONE = 3'b111);
  - the state enum {IDLE, MUL, DIV}.
- The counter width is $clog2(WIDTH)+1.
- One sub-module, alu_iter_step, is combinational and handles one iteration. Given the mode, it returns the next value of:
  - the partial product/accumulator (mul);
  - the partial remainder/quotient (div).
- The top level owns the FSM, counter, operand registers and output registers.

## Test plan
All scenarios use WIDTH=16.
- add A=0xFFFF, B=0x0001, start at cycle 0 → done at cycle 1; result=0x0000, overflow=0x0001, zero=1; busy never asserts.
- mul A=300, B=300 → busy in cycles 1–16, done at cycle 17; result=0x5F90, overflow=0x0001.
- divmod A=1000, B=7 → done at cycle 17; result=0x008E, overflow=0x0006, div_by_zero=0.
- divmod A=0x1234, B=0 → done at cycle 1; result=0xFFFF, overflow=0x1234, div_by_zero=1.
- Start ignored while busy: mul 3×5 at cycle 0, then start with add 1+1 at cycle 5.
  - The add is ignored.
  - Done at cycle 17 with result=0x000F.
  - Outputs then hold their values.
- Reset mid-operation: mul in progress, rst asserted at cycle 8.
  - All outputs become 0 immediately and state returns to IDLE.
  - No done is produced.
  - A subsequent sub 5−7 completes with result=0xFFFE, overflow=0x0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_DIVMOD = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;
  localparam logic [2:0] OP_NONE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of shift-add multiply or restoring divide on a shared 2*WIDTH accumulator.
// mul: acc = {partial product high, remaining multiplier bits}
// div: acc = {partial remainder, dividend bits shifting into quotient}
module alu_iter_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Select the next accumulator value for the active mode
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff  = trial - {1'b0, opnd_i};
    if (div_mode_i) begin
      // Remainder stays below the divisor, so trial fits in WIDTH+1 bits and diff's MSB is the sign
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle logic/arith ops, iterative unsigned mul and divmod.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CTRL,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    acc_nxt;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_ovf;

  alu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (state_q == DIV),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (acc_nxt)
  );

  // Single-cycle op results; sub_w MSB is the unsigned borrow
  always_comb begin
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, A} - {1'b0, B};
    sc_res = '0;
    sc_ovf = '0;
    case (CTRL)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_ovf = WIDTH'(add_w[WIDTH]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_ovf = WIDTH'(sub_w[WIDTH]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      default: sc_res = '0;
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (CTRL == OP_MUL) begin
            state_d = MUL;
            cnt_d   = CW'(WIDTH - 1);
            opnd_d  = A;
            acc_d   = {{WIDTH{1'b0}}, B};
            busy_d  = 1'b1;
          end else if (CTRL == OP_DIVMOD && B != '0) begin
            state_d = DIV;
            cnt_d   = CW'(WIDTH - 1);
            opnd_d  = B;
            acc_d   = {{WIDTH{1'b0}}, A};
            busy_d  = 1'b1;
          end else if (CTRL == OP_DIVMOD) begin
            res_d  = '1;
            ovf_d  = A;
            zero_d = 1'b0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            res_d  = sc_res;
            ovf_d  = sc_ovf;
            zero_d = (sc_res == '0);
            dbz_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_d = acc_nxt;
        if (cnt_q == '0) begin
          // Both modes leave the primary result in the low half, secondary in the high half
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = acc_nxt[WIDTH-1:0];
          ovf_d   = acc_nxt[AW-1:WIDTH];
          zero_d  = (acc_nxt[WIDTH-1:0] == '0);
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16.
module tb_alu_multicycle;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] ovf;
    logic         zero;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic [2:0]   CTRL;
  logic         busy, done, zero, div_by_zero;
  logic [W-1:0] result, overflow;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t last;
  exp_t mon_e;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .CTRL        (CTRL),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour; cyc is the cycle in which done must appear
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int base);
    exp_t        e;
    logic [W:0]   s;
    logic [2*W-1:0] p;
    int          lat;
    e.res = '0; e.ovf = '0; e.dbz = 1'b0; lat = 1;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.ovf = W'(s[W]); end
      3'b001: begin e.res = a - b; e.ovf = (a < b) ? 16'd1 : 16'd0; end
      3'b010: begin p = {16'd0, a} * {16'd0, b}; e.res = p[W-1:0]; e.ovf = p[2*W-1:W]; lat = W + 1; end
      3'b011: begin
        if (b == 0) begin e.res = '1; e.ovf = a; e.dbz = 1'b1; end
        else begin e.res = a / b; e.ovf = a % b; lat = W + 1; end
      end
      3'b100: e.res = a & b;
      3'b101: e.res = a | b;
      3'b110: e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    e.cyc  = base + lat;
    return e;
  endfunction

  // Drive one start strobe from a negedge; leaves the bench at the next negedge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit accept);
    exp_t e;
    e = model(op, a, b, cyc);
    CTRL = op; A = a; B = b; start = 1'b1;
    if (accept) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; CTRL = ~op;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Compare on done, otherwise require outputs to hold the last completed result
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cyc", 64'(cyc), 64'(mon_e.cyc));
          check("result", 64'(result), 64'(mon_e.res));
          check("overflow", 64'(overflow), 64'(mon_e.ovf));
          check("zero", 64'(zero), 64'(mon_e.zero));
          check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
          last = mon_e;
        end
      end else begin
        check("hold_result", 64'(result), 64'(last.res));
        check("hold_overflow", 64'(overflow), 64'(last.ovf));
      end
    end
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] ra, rb;
    last  = '{res: '0, ovf: '0, zero: 1'b0, dbz: 1'b0, cyc: 0};
    rst   = 1'b1;
    start = 1'b0;
    A = '0; B = '0; CTRL = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_zero", 64'(zero), 0);
    check("rst_dbz", 64'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // add with carry out
    issue(3'b000, 16'hFFFF, 16'h0001, 1'b1);
    check("add_busy", 64'(busy), 0);
    wait_drain("drain_add", 10);

    // mul 300*300 with busy window
    @(negedge clk);
    issue(3'b010, 16'd300, 16'd300, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      check("mul_busy_hi", 64'(busy), 1);
      @(negedge clk);
    end
    check("mul_busy_lo", 64'(busy), 0);
    wait_drain("drain_mul", 10);

    // divmod and divide by zero
    issue(3'b011, 16'd1000, 16'd7, 1'b1);
    wait_drain("drain_div", 40);
    issue(3'b011, 16'h1234, 16'h0000, 1'b1);
    check("dbz_busy", 64'(busy), 0);
    wait_drain("drain_dbz", 10);

    // start while busy is ignored
    @(negedge clk);
    issue(3'b010, 16'd3, 16'd5, 1'b1);
    repeat (4) @(negedge clk);
    issue(3'b000, 16'd1, 16'd1, 1'b0);
    wait_drain("drain_ignore", 40);
    repeat (5) @(negedge clk);

    // start in the done cycle is accepted
    issue(3'b010, 16'd7, 16'd9, 1'b1);
    repeat (16) @(negedge clk);
    issue(3'b000, 16'd40, 16'd2, 1'b1);
    wait_drain("drain_done_start", 10);

    // back-to-back single-cycle ops
    @(negedge clk);
    issue(3'b100, 16'hF0F0, 16'h3C3C, 1'b1);
    issue(3'b101, 16'hF0F0, 16'h0F0F, 1'b1);
    issue(3'b110, 16'hAAAA, 16'hAAAA, 1'b1);
    issue(3'b111, 16'h1234, 16'h5678, 1'b1);
    issue(3'b001, 16'd3, 16'd9, 1'b1);
    wait_drain("drain_b2b", 10);

    // random operations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = (i == 4) ? 16'd0 : 16'($urandom_range(0, 2 ** (i + 6)));
      issue(op, ra, rb, 1'b1);
      wait_drain("drain_rand", 40);
    end

    // reset mid-operation
    @(negedge clk);
    issue(3'b010, 16'd1234, 16'd5678, 1'b1);
    repeat (7) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    last = '{res: '0, ovf: '0, zero: 1'b0, dbz: 1'b0, cyc: 0};
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_done", 64'(done), 0);
    check("midrst_result", 64'(result), 0);
    check("midrst_overflow", 64'(overflow), 0);
    check("midrst_zero", 64'(zero), 0);
    check("midrst_dbz", 64'(div_by_zero), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(3'b001, 16'd5, 16'd7, 1'b1);
    wait_drain("drain_sub", 10);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
